counter_adder_seq: RTL and testbench

COUNTER_ADDER_SEQ -- requirements
Module: counter_adder_seq

---
 rtl/counter_adder_seq_if.sv | 18 +
 rtl/counter_adder_seq.sv | 106 ++++++++++
 tb/tb_counter_adder_seq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/counter_adder_seq_if.sv
// Bundle for counter_adder_seq: run request, live counters and the sum result handshake.
interface counter_adder_seq_if #(
  parameter int WIDTH = 4,
  parameter int NCH   = 2
);
  localparam int SUMW = WIDTH + $clog2(NCH);

  logic                 start;
  logic [NCH*WIDTH-1:0] len;
  logic                 busy;
  logic [NCH*WIDTH-1:0] cnt;
  logic [SUMW-1:0]      sum;
  logic                 sum_valid;
  logic                 sum_ready;

  modport master (output start, len, sum_ready, input busy, cnt, sum, sum_valid);
  modport slave  (input start, len, sum_ready, output busy, cnt, sum, sum_valid);
endinterface

// File: rtl/counter_adder_seq.sv
// NCH saturating run-length counters; once all reach their lengths the total is
// registered and offered on a valid/ready handshake.
module counter_adder_seq_lane #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             run,
  input  logic [WIDTH-1:0] len,
  output logic [WIDTH-1:0] cnt,
  output logic             at_len
);
  logic [WIDTH-1:0] len_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q <= '0;
      cnt   <= '0;
    end else if (load) begin
      len_q <= len;
      cnt   <= '0;
    end else if (run && (cnt != len_q)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_len = (cnt == len_q);
endmodule

module counter_adder_seq #(
  parameter int WIDTH = 4,
  parameter int NCH   = 2
) (
  input  logic                clk,
  input  logic                reset,
  counter_adder_seq_if.slave  bus
);
  localparam int SUMW = WIDTH + $clog2(NCH);

  typedef enum logic [1:0] {IDLE, RUN, SUM, DONE} state_t;

  state_t                     state, state_nxt;
  logic                       load, run_en, sum_ld;
  logic [NCH-1:0]             at_len;
  logic [NCH-1:0][WIDTH-1:0]  cnt_arr;
  logic [SUMW-1:0]            sum_c, sum_q;

  genvar i;
  generate
    for (i = 0; i < NCH; i++) begin : g_lane
      counter_adder_seq_lane #(.WIDTH(WIDTH)) u_lane (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .run    (run_en),
        .len    (bus.len[i*WIDTH +: WIDTH]),
        .cnt    (cnt_arr[i]),
        .at_len (at_len[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    run_en    = 1'b0;
    sum_ld    = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        load      = 1'b1;
        state_nxt = RUN;
      end
      // Completion is judged on current counts, so the last RUN cycle never increments.
      RUN: if (&at_len) state_nxt = SUM;
           else         run_en    = 1'b1;
      SUM: begin
        sum_ld    = 1'b1;
        state_nxt = DONE;
      end
      DONE: if (bus.sum_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < NCH; k++)
      sum_c = sum_c + {{(SUMW-WIDTH){1'b0}}, cnt_arr[k]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      sum_q <= '0;
    else if (sum_ld) sum_q <= sum_c;
  end

  assign bus.busy      = (state != IDLE);
  assign bus.sum_valid = (state == DONE);
  assign bus.sum       = sum_q;
  assign bus.cnt       = cnt_arr;
endmodule

// File: tb/tb_counter_adder_seq.sv
// Directed checks of counter_adder_seq at default size and at NCH=4/WIDTH=8.
module tb_counter_adder_seq;
  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  counter_adder_seq_if #(.WIDTH(4), .NCH(2)) bus_a ();
  counter_adder_seq_if #(.WIDTH(8), .NCH(4)) bus_b ();

  counter_adder_seq #(.WIDTH(4), .NCH(2)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  counter_adder_seq #(.WIDTH(8), .NCH(4)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Start a run on the default instance and wait (bounded) for sum_valid.
  task automatic run_a(input string tag, input logic [3:0] l0, input logic [3:0] l1,
                       input int exp_lat, input logic [4:0] exp_sum);
    int k;
    @(negedge clk);
    bus_a.len   = {l1, l0};
    bus_a.start = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_busy"}, 32'(bus_a.busy), 1);
    @(negedge clk);
    bus_a.start = 1'b0;
    k = 0;
    while (!bus_a.sum_valid && k < 600) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_lat"}, k, exp_lat);
    chk({tag, "_sum"}, 32'(bus_a.sum), 32'(exp_sum));
    chk({tag, "_cnt"}, 32'(bus_a.cnt), {24'd0, l1, l0});
  endtask

  task automatic accept_a(input string tag, input logic with_start, input logic [4:0] exp_sum);
    @(negedge clk);
    bus_a.sum_ready = 1'b1;
    bus_a.start     = with_start;
    @(posedge clk); #1;
    chk({tag, "_acc_busy"}, 32'(bus_a.busy), 0);
    chk({tag, "_acc_vld"},  32'(bus_a.sum_valid), 0);
    chk({tag, "_acc_sum"},  32'(bus_a.sum), 32'(exp_sum));
    @(negedge clk);
    bus_a.sum_ready = 1'b0;
    bus_a.start     = 1'b0;
  endtask

  initial begin
    int k;
    reset           = 1'b0;
    bus_a.start     = 1'b0;
    bus_a.len       = '0;
    bus_a.sum_ready = 1'b0;
    bus_b.start     = 1'b0;
    bus_b.len       = '0;
    bus_b.sum_ready = 1'b0;
    #2;
    chk("rst_busy", 32'(bus_a.busy), 0);
    chk("rst_vld",  32'(bus_a.sum_valid), 0);
    chk("rst_cnt",  32'(bus_a.cnt), 0);
    chk("rst_sum",  32'(bus_a.sum), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    run_a("r4_9", 4'd4, 4'd9, 11, 5'd13);
    accept_a("r4_9", 1'b0, 5'd13);
    // Counters hold after the run ends.
    chk("r4_9_cnt_hold", 32'(bus_a.cnt), 32'h94);

    run_a("r15", 4'd15, 4'd15, 17, 5'd30);
    accept_a("r15", 1'b0, 5'd30);

    run_a("r0", 4'd0, 4'd0, 2, 5'd0);
    accept_a("r0", 1'b0, 5'd0);

    // Stall in DONE with start pulses and len changes.
    run_a("stall", 4'd3, 4'd5, 7, 5'd8);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus_a.start = ~c[0];
      bus_a.len   = 8'($urandom);
      @(posedge clk); #1;
      chk("stall_vld",  32'(bus_a.sum_valid), 1);
      chk("stall_sum",  32'(bus_a.sum), 8);
      chk("stall_busy", 32'(bus_a.busy), 1);
      chk("stall_cnt",  32'(bus_a.cnt), 32'h53);
    end
    accept_a("stall", 1'b1, 5'd8);
    @(posedge clk); #1;
    chk("stall_norestart", 32'(bus_a.busy), 0);

    // Asynchronous reset between edges in RUN.
    @(negedge clk);
    bus_a.len   = {4'd7, 4'd7};
    bus_a.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_a.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus_a.busy), 0);
    chk("mid_rst_cnt",  32'(bus_a.cnt), 0);
    chk("mid_rst_sum",  32'(bus_a.sum), 0);
    chk("mid_rst_vld",  32'(bus_a.sum_valid), 0);
    @(negedge clk);
    reset = 1'b1;
    run_a("post_rst", 4'd2, 4'd3, 5, 5'd5);
    accept_a("post_rst", 1'b0, 5'd5);

    // Wide instance: four channels of 255.
    @(negedge clk);
    bus_b.len   = {4{8'hFF}};
    bus_b.start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    bus_b.start = 1'b0;
    k = 0;
    while (!bus_b.sum_valid && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    chk("wide_lat", k, 257);
    chk("wide_sum", 32'(bus_b.sum), 1020);
    chk("wide_cnt", bus_b.cnt, 32'hFFFF_FFFF);
    @(negedge clk);
    bus_b.sum_ready = 1'b1;
    @(posedge clk); #1;
    chk("wide_acc_vld", 32'(bus_b.sum_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
